// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory master and its lane aligner.
package data_mem_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } state_t;

  // Reserved size is reported as misaligned so one test covers both.
  function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for 32-bit words: load extraction with
// sign/zero extension, and sub-word merge for read-modify-write stores.
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_rd,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [1:0]       i_addr_lo,
  input  size_t            i_size,
  input  logic             i_unsigned,
  output logic [WIDTH-1:0] o_ext,
  output logic [WIDTH-1:0] o_merged
);

  logic [7:0]  w_byte [4];
  logic [3:0]  w_lane_sel;
  logic [7:0]  w_src [4];
  logic [7:0]  w_b;
  logic [15:0] w_h;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_byte[gi]     = i_rd[8*gi +: 8];
    assign w_lane_sel[gi] = (i_size == SZ_W) ||
                            (i_size == SZ_H && i_addr_lo[1] == ((gi / 2) != 0)) ||
                            (i_size == SZ_B && i_addr_lo == 2'(gi));
    // Store data is right-justified, so sub-word sources come from the low lanes.
    assign w_src[gi]      = (i_size == SZ_W) ? i_wdata[8*gi +: 8] :
                            (i_size == SZ_H) ? i_wdata[8*(gi % 2) +: 8] :
                                               i_wdata[7:0];
    assign o_merged[8*gi +: 8] = w_lane_sel[gi] ? w_src[gi] : w_byte[gi];
  end

  assign w_b = w_byte[i_addr_lo];
  assign w_h = i_addr_lo[1] ? {w_byte[3], w_byte[2]} : {w_byte[1], w_byte[0]};

  always_comb begin
    o_ext = '0;
    case (i_size)
      SZ_B:    o_ext = {{(WIDTH-8){~i_unsigned & w_b[7]}}, w_b};
      SZ_H:    o_ext = {{(WIDTH-16){~i_unsigned & w_h[15]}}, w_h};
      SZ_W:    o_ext = i_rd;
      default: o_ext = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_master.sv
// Multi-cycle load/store initiator for a word-addressed data memory.
// Optional DATA_MEM_MASTER_STATS_EN adds saturating load/store/error counters.
module data_mem_master
  import data_mem_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
`ifdef DATA_MEM_MASTER_STATS_EN
  ,
  output logic [15:0]      ld_cnt,
  output logic [15:0]      st_cnt,
  output logic [15:0]      err_cnt
`endif
);

  state_t              r_state;
  logic                r_we;
  logic                r_unsigned;
  size_t               r_size;
  logic [1:0]          r_lane;
  logic [ADDR_W-1:0]   r_mem_adr;
  logic [WIDTH-1:0]    r_mem_wd;
  logic [WIDTH-1:0]    r_rsp_rdata;
  logic                r_rsp_valid;
  logic                r_rsp_err;

  size_t               w_req_size;
  logic                w_illegal;
  logic [WIDTH-1:0]    w_ext;
  logic [WIDTH-1:0]    w_merged;

  assign w_req_size = size_t'(req_size);
  assign w_illegal  = misaligned(w_req_size, req_addr[1:0]) ||
                      (req_addr[WIDTH-1:ADDR_W+2] != '0);

  // r_mem_wd holds the raw store data until ACCESS, then the merged word.
  mem_lane_align #(.WIDTH(WIDTH)) u_align (
    .i_rd       (mem_rd),
    .i_wdata    (r_mem_wd),
    .i_addr_lo  (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_ext      (w_ext),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= SZ_B;
      r_lane      <= 2'b00;
      r_mem_adr   <= '0;
      r_mem_wd    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= w_req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_mem_adr  <= req_addr[ADDR_W+1:2];
            r_mem_wd   <= req_wdata;
            if (w_illegal) begin
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!r_we) begin
            r_rsp_rdata <= w_ext;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (r_size == SZ_W) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_mem_wd <= w_merged;
            r_state  <= WRITE;
          end
        end
        WRITE: begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset kills a pending write at once.
  assign mem_we    = (r_state == WRITE) ||
                     (r_state == ACCESS && r_we && r_size == SZ_W);
  assign req_ready = rst && (r_state == IDLE);
  assign mem_adr   = {{(WIDTH-ADDR_W){1'b0}}, r_mem_adr};
  assign mem_wd    = r_mem_wd;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

`ifdef DATA_MEM_MASTER_STATS_EN
  logic [2:0]  w_cnt_inc;
  logic [15:0] r_cnt [3];

  assign w_cnt_inc[0] = (r_state == RESP) && !r_rsp_err && !r_we;
  assign w_cnt_inc[1] = (r_state == RESP) && !r_rsp_err && r_we;
  assign w_cnt_inc[2] = (r_state == RESP) && r_rsp_err;

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        r_cnt[gi] <= '0;
      else if (w_cnt_inc[gi] && r_cnt[gi] != 16'hFFFF)
        r_cnt[gi] <= r_cnt[gi] + 16'd1;
    end
  end

  assign ld_cnt  = r_cnt[0];
  assign st_cnt  = r_cnt[1];
  assign err_cnt = r_cnt[2];
`endif

endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- Initiator side of the word-addressed data memory port: multi-cycle load/store unit that turns CPU byte-addressed requests into memory word accesses (We/Data_Adr/WD out, RD in).
- Memory contract: read is combinational from address; write commits at posedge when We=1.
- Adds byte/half/word sizes, sign/zero extension, read-modify-write for sub-word stores, and alignment/range checks.
- Sits between the multi-cycle datapath control FSM and the data memory.

Parameters:
- WIDTH, 32, data and address width.
- ADDR_W, 9, memory word-index width (512 words); the byte address space is 4*2^ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  unit idle, can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected (misaligned, out of range, reserved size)
- mem_we  out  1  to memory We
- mem_adr  out  WIDTH  to memory Data_Adr: word index, zero-extended
- mem_wd  out  WIDTH  to memory WD
- mem_rd  in  WIDTH  from memory RD

Behaviour:
- FSM states: IDLE, ACCESS, WRITE, RESP. On reset: IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_adr=0, mem_wd=0, req_ready=0 while rst low.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/size/unsigned/addr/wdata.
  - If the request is illegal, go to RESP with err=1.
  - Otherwise go to ACCESS.
- Illegal request: size=11; half with addr[0]=1; word with addr[1:0]!=0; or addr[WIDTH-1:ADDR_W+2]!=0.
- Illegal requests never assert mem_we.
- mem_adr = latched addr[ADDR_W+1:2], held from acceptance until the next acceptance.
- ACCESS:
  - Load: at the edge, capture the lane selected by addr[1:0] from mem_rd, extend, store to rsp_rdata. Go to RESP.
  - Word store: mem_we=1, mem_wd=wdata. Go to RESP.
  - Sub-word store: mem_we=0. Register mem_rd merged with wdata in the addressed byte/half lane. Go to WRITE.
- WRITE: mem_we=1, mem_wd=merged word. Go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- rsp_rdata and rsp_err are registered and hold until the next response.
- Latency from the acceptance edge (rsp_valid is high during the Nth cycle after it):
  - error: N=1
  - load or word store: N=2
  - sub-word store: N=3
- Requests are accepted only in IDLE. With req_valid held high, the next acceptance is at the edge ending the IDLE cycle after RESP.
- mem_we is decoded combinationally from state. An asynchronous reset during ACCESS or WRITE drops mem_we immediately: the pending write is lost and memory is unchanged.
- Memory contents are never initialised by this block.
- Little-endian lanes: byte at addr[1:0]=k occupies bits 8k+7:8k.

Optional Feature:
- Macro DATA_MEM_MASTER_STATS_EN.
- Defined: adds outputs ld_cnt, st_cnt, err_cnt, each 16 bits. Each increments on its response type at RESP, saturates at 0xFFFF, and clears on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package data_mem_pkg holds:
  - size_t enum: SZ_B, SZ_H, SZ_W, SZ_RSV
  - state_t enum: IDLE, ACCESS, WRITE, RESP
  - default constants for WIDTH and ADDR_W
- Sub-module mem_lane_align (combinational) provides both directions:
  - extract: rd word, addr[1:0], size, unsigned -> extended data
  - merge: rd word, wdata, addr[1:0], size -> merged word

Test Plan:
- Bench memory preloaded with word[2]=0x00000008. Word load at 0x8: rsp_valid in the 2nd cycle after accept, rsp_rdata=0x00000008, rsp_err=0, mem_we stays 0.
- Word store 0xDEADBEEF at 0x10, then:
  - signed byte load at 0x13 returns 0xFFFFFFDE
  - unsigned byte load at 0x12 returns 0x000000AD
  - signed half load at 0x10 returns 0xFFFFBEEF
- Half store 0x00001234 at 0x12 over 0xDEADBEEF: mem_we high for exactly one cycle (WRITE), word[4] becomes 0x1234BEEF, rsp_valid in the 3rd cycle after accept.
- Error cases, each giving rsp_valid with rsp_err=1 in the 1st cycle after accept, rsp_rdata=0, and no mem_we:
  - word load at 0x6
  - half store at 0x801
  - byte load at 0x800 (out of range)
  - size=11
- Assert rst low during WRITE of a half store to 0x10 holding 0xDEADBEEF:
  - mem_we falls in the same cycle and all outputs return to reset values
  - word stays 0xDEADBEEF
  - after release, req_ready=1 and a load at 0x10 returns 0xDEADBEEF
- req_valid held high for two back-to-back word loads: second acceptance exactly 3 cycles after the first. With DATA_MEM_MASTER_STATS_EN defined, ld_cnt=2.
